// File: rtl/pipe_exec_pkg.sv
// Shared opcode encoding, FSM states and opcode classification helpers for the
// pipelined execute stage.
package pipe_exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ORI  = 4'h7;
    localparam logic [3:0] OP_XORI = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_SUBI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_MULL = 4'hD;
    localparam logic [3:0] OP_MULH = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULL) || (op == OP_MULH);
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return (op != OP_JMP) && (op != OP_BEQ) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/pipe_exec_unit_iter_mult.sv
// Iterative unsigned shift-add multiplier retiring MUL_BITS multiplier bits per
// cycle; done_o and product_o are combinational during the final step.
module iter_mult #(
    parameter int DATA_W   = 16,
    parameter int MUL_BITS = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] partial_s;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    // Partial product of the current multiplier digit and the next accumulator value.
    always_comb begin
        partial_s = mcand_q * {{(2*DATA_W-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
        acc_d     = acc_q + partial_s;
    end

    assign done_o    = busy_q & (cnt_q == CNT_W'(1));
    assign product_o = acc_d;

    // Operand load, per-step shift/accumulate and abort handling.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mcand_q  <= {(2*DATA_W){1'b0}};
            acc_q    <= {(2*DATA_W){1'b0}};
            mplier_q <= {DATA_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
        end else if (abort_i) begin
            acc_q  <= {(2*DATA_W){1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= {(2*DATA_W){1'b0}};
            cnt_q    <= CNT_W'(STEPS);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            cnt_q    <= cnt_q - CNT_W'(1);
            busy_q   <= (cnt_q != CNT_W'(1));
        end
    end

endmodule

// File: rtl/pipe_exec_unit.sv
// Execute stage: ALU, branch and iterative multiply with a valid/ready result port.
// Optional macro EXEC_MUL_REUSE_EN keeps the last product for 1-cycle repeat multiplies.
module pipe_exec_unit
    import pipe_exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int PC_W     = 12,
    parameter int MUL_BITS = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_op_i,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic [DATA_W-1:0] in_imm_i,
    input  logic [REG_AW-1:0] in_rd_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [REG_AW-1:0] out_rd_o,
    output logic              out_wen_o,
    output logic              br_taken_o,
    output logic [PC_W-1:0]   br_target_o
);

    state_e              state_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [REG_AW-1:0]   out_rd_q;
    logic                out_wen_q;
    logic                br_taken_q;
    logic [PC_W-1:0]     br_target_q;
    logic                mul_hi_q;

    logic                xfer_s;
    logic                mul_op_s;
    logic                reuse_hit_s;
    logic                mul_start_s;
    logic                br_d;
    logic [DATA_W-1:0]   res_d;
    logic [DATA_W-1:0]   mul_res_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] mul_prod_s;

`ifdef EXEC_MUL_REUSE_EN
    logic                reuse_vld_q;
    logic [DATA_W-1:0]   reuse_a_q;
    logic [DATA_W-1:0]   reuse_b_q;
    logic [2*DATA_W-1:0] reuse_prod_q;
`endif

    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = (b > a) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ANDI: r = b & imm;
            OP_ORI:  r = b | imm;
            OP_XORI: r = b ^ imm;
            OP_ADDI: r = b + imm;
            OP_SUBI: r = b - imm;
            default: r = {DATA_W{1'b0}};
        endcase
        return r;
    endfunction

    assign in_ready_o = (state_q == ST_IDLE) & (~out_valid_q | out_ready_i) & ~flush_i;

    // Transfer decode, reuse lookup and single-cycle result selection.
    always_comb begin
        xfer_s   = in_valid_i & in_ready_o;
        mul_op_s = is_mul_op(in_op_i);
        br_d     = (in_op_i == OP_JMP) |
                   ((in_op_i == OP_BEQ) & (in_a_i == {DATA_W{1'b0}}));
`ifdef EXEC_MUL_REUSE_EN
        reuse_hit_s = reuse_vld_q & (in_a_i == reuse_a_q) & (in_b_i == reuse_b_q);
        if (mul_op_s) begin
            res_d = (in_op_i == OP_MULH) ? reuse_prod_q[2*DATA_W-1:DATA_W]
                                         : reuse_prod_q[DATA_W-1:0];
        end else begin
            res_d = alu_eval(in_op_i, in_a_i, in_b_i, in_imm_i);
        end
`else
        reuse_hit_s = 1'b0;
        res_d       = alu_eval(in_op_i, in_a_i, in_b_i, in_imm_i);
`endif
        mul_start_s = xfer_s & mul_op_s & ~reuse_hit_s;
        mul_res_s   = mul_hi_q ? mul_prod_s[2*DATA_W-1:DATA_W] : mul_prod_s[DATA_W-1:0];
    end

    iter_mult #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mult (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start_i   (mul_start_s),
        .abort_i   (flush_i),
        .a_i       (in_a_i),
        .b_i       (in_b_i),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );

    // FSM and registered result/branch outputs; flush overrides everything.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_rd_q    <= {REG_AW{1'b0}};
            out_wen_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= {PC_W{1'b0}};
            mul_hi_q    <= 1'b0;
        end else if (flush_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
        end else begin
            br_taken_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer_s) begin
                        out_rd_q  <= in_rd_i;
                        out_wen_q <= writes_reg(in_op_i);
                        if (mul_start_s) begin
                            state_q     <= ST_MUL;
                            out_valid_q <= 1'b0;
                            mul_hi_q    <= (in_op_i == OP_MULH);
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_d;
                            br_taken_q  <= br_d;
                            if (br_d) begin
                                br_target_q <= in_imm_i[PC_W-1:0];
                            end
                        end
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= mul_res_s;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef EXEC_MUL_REUSE_EN
    // Last completed product and its operands; invalid while a new multiply runs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            reuse_vld_q  <= 1'b0;
            reuse_a_q    <= {DATA_W{1'b0}};
            reuse_b_q    <= {DATA_W{1'b0}};
            reuse_prod_q <= {(2*DATA_W){1'b0}};
        end else if (flush_i) begin
            reuse_vld_q <= 1'b0;
        end else if (mul_start_s) begin
            reuse_vld_q <= 1'b0;
            reuse_a_q   <= in_a_i;
            reuse_b_q   <= in_b_i;
        end else if (mul_done_s) begin
            reuse_vld_q  <= 1'b1;
            reuse_prod_q <= mul_prod_s;
        end
    end
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_rd_o    = out_rd_q;
    assign out_wen_o   = out_wen_q;
    assign br_taken_o  = br_taken_q;
    assign br_target_o = br_target_q;

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Randomized self-checking bench for pipe_exec_unit against a transaction-level
// reference model (result value, latency countdown, output occupancy).
module tb_pipe_exec_unit;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int PW    = 12;
    localparam int MB    = 1;
    localparam int STEPS = DW / MB;
`ifdef EXEC_MUL_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = 4'h0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] in_imm = '0;
    logic [AW-1:0] in_rd = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rd;
    logic          out_wen;
    logic          br_taken;
    logic [PW-1:0] br_target;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            m_ov, m_wen, m_br;
    logic [DW-1:0] m_data, p_data;
    logic [AW-1:0] m_rd, p_rd;
    logic [PW-1:0] m_tgt;
    int            m_left;
    bit            r_vld;
    logic [DW-1:0] r_a, r_b;

    pipe_exec_unit #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW), .MUL_BITS(MB)) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_imm_i    (in_imm),
        .in_rd_i     (in_rd),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_rd_o    (out_rd),
        .out_wen_o   (out_wen),
        .br_taken_o  (br_taken),
        .br_target_o (br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic [DW-1:0] imm);
        logic [2*DW-1:0] prod;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return (b > a) ? DW'(1) : DW'(0);
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return b & imm;
            4'h7: return b | imm;
            4'h8: return b ^ imm;
            4'h9: return b + imm;
            4'hA: return b - imm;
            4'hD: return prod[DW-1:0];
            4'hE: return prod[2*DW-1:DW];
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 0; m_wen = 0; m_br = 0; m_left = 0; r_vld = 0;
        m_data = '0; m_rd = '0; m_tgt = '0; p_data = '0; p_rd = '0; r_a = '0; r_b = '0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input logic fl, input logic ordy, input logic iv, input logic [3:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic [AW-1:0] rd);
        bit exp_rdy, xfer, is_mul, hit, nxt_br;
        @(negedge clk);
        flush = fl; out_ready = ordy; in_valid = iv;
        in_op = op; in_a = a; in_b = b; in_imm = imm; in_rd = rd;
        #1;
        exp_rdy = (m_left == 0) && (!m_ov || ordy) && !fl;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_wen", 32'(out_wen), 32'(m_wen));
            chk("out_rd", 32'(out_rd), 32'(m_rd));
            if (m_wen) chk("out_data", 32'(out_data), 32'(m_data));
        end
        chk("br_taken", 32'(br_taken), 32'(m_br));
        if (m_br) chk("br_target", 32'(br_target), 32'(m_tgt));

        xfer   = iv && exp_rdy;
        nxt_br = 0;
        if (fl) begin
            m_ov = 0; m_left = 0; r_vld = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ov = 1; m_data = p_data; m_rd = p_rd; m_wen = 1; r_vld = 1;
            end
        end else if (xfer) begin
            is_mul = (op == 4'hD) || (op == 4'hE);
            hit    = REUSE && r_vld && (a == r_a) && (b == r_b);
            if (is_mul && !hit) begin
                m_left = STEPS; m_ov = 0; r_vld = 0; r_a = a; r_b = b;
                p_data = ref_result(op, a, b, imm); p_rd = rd;
            end else begin
                m_ov = 1; m_data = ref_result(op, a, b, imm); m_rd = rd;
                m_wen = !(op == 4'hB || op == 4'hC || op == 4'hF);
                if (op == 4'hB || (op == 4'hC && a == '0)) begin
                    nxt_br = 1; m_tgt = imm[PW-1:0];
                end
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        m_br = nxt_br;
    endtask

    initial begin
        logic [3:0]    r_op;
        logic [DW-1:0] ra, rb, rimm;
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_br_target", 32'(br_target), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: ALU basics, wrap, slt
        step(0, 1, 1, 4'h0, 16'h0003, 16'h0005, 16'h0000, 4'd2);
        step(0, 1, 1, 4'hA, 16'h1234, 16'h0000, 16'h0001, 4'd3);
        step(0, 1, 1, 4'h2, 16'h0005, 16'h0007, 16'h0000, 4'd4);
        // Multiply high then low on all-ones operands, add offered throughout
        step(0, 1, 1, 4'hE, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd5);
        repeat (STEPS) step(0, 1, 1, 4'h0, 16'h0001, 16'h0001, 16'h0000, 4'd6);
        step(0, 1, 1, 4'hD, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd7);
        repeat (STEPS + 1) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        // Branches
        step(0, 1, 1, 4'hC, 16'h0000, 16'h0000, 16'h002A, 4'd1);
        step(0, 1, 1, 4'hC, 16'h0001, 16'h0000, 16'h0033, 4'd1);
        step(0, 1, 1, 4'hB, 16'h0001, 16'h0000, 16'hF155, 4'd1);
        // Backpressure then back-to-back
        step(0, 1, 1, 4'h0, 16'h0010, 16'h0020, 16'h0000, 4'd8);
        step(0, 0, 1, 4'h0, 16'h0100, 16'h0200, 16'h0000, 4'd9);
        step(0, 0, 1, 4'h0, 16'h0100, 16'h0200, 16'h0000, 4'd9);
        step(0, 1, 1, 4'h0, 16'h0100, 16'h0200, 16'h0000, 4'd9);
        step(0, 1, 1, 4'h5, 16'h00F0, 16'h0FF0, 16'h0000, 4'd10);
        step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        // Flush at cycle 5 of a multiply
        step(0, 1, 1, 4'hD, 16'h0123, 16'h0456, 16'h0000, 4'd11);
        repeat (4) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        step(1, 1, 1, 4'h0, 16'h0001, 16'h0002, 16'h0000, 4'd12);
        repeat (2) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        // Repeat multiply on identical operands (single-cycle when reuse is built in)
        step(0, 1, 1, 4'hE, 16'h1234, 16'h5678, 16'h0000, 4'd13);
        repeat (STEPS) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        step(0, 1, 1, 4'hE, 16'h1234, 16'h5678, 16'h0000, 4'd14);
        repeat (STEPS + 1) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        // Reset asserted mid-multiply
        step(0, 1, 1, 4'hD, 16'h0009, 16'h0007, 16'h0000, 4'd15);
        repeat (3) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midmul_rst_valid", 32'(out_valid), 32'd0);
        chk("midmul_rst_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (STEPS + 2) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r_op = 4'($urandom_range(0, 15));
            ra   = ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom);
            rb   = ($urandom_range(0, 1) == 0) ? DW'(16'h00FF) : DW'($urandom);
            if ($urandom_range(0, 2) == 0) ra = DW'(16'h0101);
            rimm = DW'($urandom);
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), r_op, ra, rb, rimm, AW'($urandom));
        end
        repeat (STEPS + 2) step(0, 1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_exec_unit.md
Name: pipe_exec_unit

Overview:
Parametrised execute stage for the team's pipelined CPU. It is the successor of the fixed 16-bit execute logic. It takes decoded operations from the decode stage through a valid/ready handshake and produces registered ALU, branch and multiply results for the memory/writeback stage. Multiplies run on an internal iterative multiplier that stalls upstream; flush kills in-flight work after a taken branch.

Parameters:
DATA_W, 16, operand/result width (>=4, even)
REG_AW, 4, destination register index width
PC_W, 12, program counter width
MUL_BITS, 1, multiplier bits retired per cycle; must divide DATA_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode offers an operation
in_ready  out  1  unit accepts the operation this cycle
in_op  in  4  opcode, team ISA encoding
in_a  in  DATA_W  operand 1 (register s3)
in_b  in  DATA_W  operand 2 (register s2)
in_imm  in  DATA_W  sign/zero-extended immediate
in_rd  in  REG_AW  destination register
flush  in  1  kill in-flight operation and output
out_valid  out  1  result register holds a valid result
out_ready  in  1  downstream consumes the result
out_data  out  DATA_W  result value
out_rd  out  REG_AW  destination register
out_wen  out  1  result is written to the register bank
br_taken  out  1  one-cycle pulse: redirect the PC
br_target  out  PC_W  redirect address

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_valid, out_wen and br_taken = 0; out_data, out_rd and br_target = 0; multiplier registers cleared.
- Handshake: transfer occurs when in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Output: out_valid holds until out_ready; out_data, out_rd and out_wen are stable while out_valid=1 & out_ready=0.
- Opcodes (all arithmetic mod 2^DATA_W):
  - 0 add a+b; 1 sub a-b; 2 slt (b>a unsigned ? 1 : 0)
  - 3 and; 4 or; 5 xor
  - 6 andi b&imm; 7 ori; 8 xori; 9 addi b+imm; A subi b-imm
  - B jump
  - C beq
  - D mul low; E mul high (unsigned DATA_W x DATA_W -> 2*DATA_W)
  - F nop
  - Opcodes 0-A and D/E set out_wen=1. B, C and F set out_wen=0.
- ALU ops 0-A and F: latency 1; the result appears in the cycle after transfer.
- Branch/jump:
  - B: br_taken=1 next cycle, br_target = imm[PC_W-1:0].
  - C: br_taken = (a==0), br_target = imm[PC_W-1:0].
  - br_taken is a single-cycle pulse issued with out_valid, regardless of out_ready.
- FSM IDLE -> MUL -> IDLE:
  - D/E transfer loads the multiplicand, multiplier and step counter, then enters MUL.
  - Each MUL cycle retires MUL_BITS bits.
  - After DATA_W/MUL_BITS cycles, the unit writes low half (D) or high half (E) to out_data, sets out_valid and returns to IDLE.
  - Latency = DATA_W/MUL_BITS + 1 cycles. in_ready=0 throughout MUL.
- Flush has priority over every other event. In the cycle it is seen:
  - out_valid := 0 and br_taken := 0.
  - MUL aborts to IDLE.
  - An input offered the same cycle is not accepted.
- Simultaneous out_ready and a new transfer: the old result retires and the new one is loaded in the same edge, with no bubble.
- Reset asserted mid-multiply: immediate return to the reset state with no partial result.

Optional Feature:
Macro EXEC_MUL_REUSE_EN.
- Defined: the unit stores the last full 2*DATA_W product and its operands. A D/E op whose a and b match the stored operands (and the stored product is valid) completes with latency 1 and no MUL state. Flush, reset and any new multiply invalidate or replace the stored product.
- Undefined: every D/E op takes the full iterative latency.

Decomposition:
Package pipe_exec_pkg:
- opcode localparams OP_ADD..OP_NOP (4'h0..4'hF)
- FSM state enum {ST_IDLE, ST_MUL}
One natural sub-module: iter_mult (start, a, b -> done, product[2*DATA_W-1:0]), parametrised by DATA_W and MUL_BITS.

Test Plan:
- Reset then add a=0x0003, b=0x0005, rd=2 -> next cycle out_valid=1, out_data=0x0008, out_rd=2, out_wen=1.
- subi b=0x0000, imm=0x0001 -> out_data=0xFFFF (wrap). slt a=5, b=7 -> out_data=1.
- mul high a=0xFFFF, b=0xFFFF, MUL_BITS=1 -> in_ready=0 for 16 cycles; out_data=0xFFFE on cycle 17; a mul low on the same operands gives 0x0001.
- beq a=0, imm=0x02A -> br_taken pulse, br_target=0x02A. With a=1, br_taken stays 0.
- Hold out_ready=0 with out_valid=1, offer add -> in_ready=0 and the output is stable. Then out_ready=1 together with a new add -> back-to-back results with no bubble.
- flush at cycle 5 of a multiply -> out_valid stays 0 and in_ready returns to 1 the next cycle. With EXEC_MUL_REUSE_EN, a repeated mul high on matching operands completes in 1 cycle.
